// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator for the fir output stream: sums DECIM samples,
// rounds/scales/saturates the sum and queues results in a small output FIFO.
module fir_decimator #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    drop,
  output logic                    sat
);

  localparam int ACC_W = IN_W + $clog2(DECIM);
  localparam int SUM_W = ACC_W + 1;
  localparam int PH_W  = $clog2(DECIM);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Half an output LSB, or zero when no shift is applied.
  localparam logic signed [SUM_W-1:0] RND     = (SUM_W'(1) << SHIFT) >> 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic        [PH_W-1:0]   phase;
  logic                     phase_last;
  logic signed [ACC_W-1:0]  dump;
  logic                     dump_valid;

  logic signed [SUM_W-1:0]  rounded;
  logic signed [SUM_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  scaled;
  logic                     clamp;

  logic        [OUT_W-1:0]  mem [DEPTH];
  logic        [PTR_W-1:0]  rd_ptr;
  logic        [PTR_W-1:0]  wr_ptr;
  logic        [CNT_W-1:0]  count;
  logic                     full;
  logic                     do_read;
  logic                     do_write;

  assign acc_sum    = acc + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign phase_last = (phase == PH_W'(DECIM - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      phase      <= '0;
      dump       <= '0;
      dump_valid <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (in_valid) begin
        if (phase_last) begin
          dump       <= acc_sum;
          dump_valid <= 1'b1;
          acc        <= '0;
          phase      <= '0;
        end else begin
          acc   <= acc_sum;
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

  // One extra bit keeps the rounding add free of overflow before the shift.
  always_comb begin
    rounded = {dump[ACC_W-1], dump} + RND;
    shifted = rounded >>> SHIFT;
    clamp   = 1'b0;
    scaled  = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      scaled = {1'b0, {(OUT_W-1){1'b1}}};
      clamp  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      scaled = {1'b1, {(OUT_W-1){1'b0}}};
      clamp  = 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign full      = (count == CNT_W'(DEPTH));
  assign do_read   = out_valid & out_ready;
  assign do_write  = dump_valid & (~full | do_read);

  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[wr_ptr] <= scaled;
    end
  end

  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      drop <= dump_valid & ~do_write;
      if (dump_valid && clamp) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: expected results are queued as groups are
// issued and a negedge monitor compares each accepted FIFO output.
module tb_fir_decimator;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  logic                    clock;
  logic                    reset;
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    drop;
  logic                    sat;

  int checks;
  int failures;
  int drop_count;
  int drop_base;
  int exp_q[$];

  fir_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(4), .SHIFT(2), .DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .drop(drop),
    .sat(sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && drop) drop_count++;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got %0d, expected no output", $signed(out_data));
      end else begin
        check_output("out_data", int'($signed(out_data)), exp_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input int value);
    in_valid = 1'b1;
    in_data  = IN_W'(value);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_group(input int v0, input int v1, input int v2, input int v3, input int expected);
    exp_q.push_back(expected);
    apply_stimulus(v0);
    apply_stimulus(v1);
    apply_stimulus(v2);
    apply_stimulus(v3);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: drain timed out, %0d results still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    drop_count = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_out_data", int'($signed(out_data)), 0);
    check_output("reset_drop", int'(drop), 0);
    check_output("reset_sat", int'(sat), 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Basic: single-cycle result after the edge following the last sample
    out_ready = 1'b1;
    send_group(1, 2, 3, 4, 3);
    @(negedge clock);
    check_output("basic_not_yet_valid", int'(out_valid), 0);
    @(negedge clock);
    check_output("basic_valid", int'(out_valid), 1);
    @(negedge clock);
    check_output("basic_one_cycle", int'(out_valid), 0);
    check_output("basic_sat", int'(sat), 0);

    send_group(-5, -5, -5, -6, -5);
    wait_drain("negative", 20);

    // Saturation and sticky sat
    send_group(1000, 1000, 1000, 1000, 127);
    wait_drain("sat_pos", 20);
    check_output("sat_set", int'(sat), 1);
    send_group(0, 0, 0, 0, 0);
    wait_drain("sat_zero", 20);
    check_output("sat_sticky", int'(sat), 1);
    send_group(-1000, -1000, -1000, -1000, -128);
    wait_drain("sat_neg", 20);

    // Backpressure: groups 5 and 6 find the FIFO full
    out_ready = 1'b0;
    drop_base = drop_count;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) send_group(k, k, k, k, k);
      else begin
        apply_stimulus(k); apply_stimulus(k); apply_stimulus(k); apply_stimulus(k);
      end
    end
    repeat (3) @(negedge clock);
    check_output("bp_drops", drop_count - drop_base, 2);
    check_output("bp_held_valid", int'(out_valid), 1);
    check_output("bp_head", int'($signed(out_data)), 1);
    out_ready = 1'b1;
    wait_drain("bp_drain", 20);
    check_output("bp_empty", int'(out_valid), 0);

    // Gapped input
    exp_q.push_back(3);
    for (int v = 1; v <= 4; v++) begin
      apply_stimulus(v);
      repeat (2) begin
        @(posedge clock);
        #1;
      end
    end
    wait_drain("gapped", 20);

    // Simultaneous read and write while full
    out_ready = 1'b0;
    drop_base = drop_count;
    for (int k = 1; k <= 4; k++) send_group(k, k, k, k, k);
    exp_q.push_back(5);
    apply_stimulus(5); apply_stimulus(5); apply_stimulus(5); apply_stimulus(5);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_output("full_rw_no_drop", drop_count - drop_base, 0);
    check_output("full_rw_head", int'($signed(out_data)), 2);
    out_ready = 1'b1;
    wait_drain("full_rw_drain", 20);

    // Reset in mid-group discards the partial sum and clears sat
    apply_stimulus(100);
    apply_stimulus(100);
    reset = 1'b0;
    @(negedge clock);
    check_output("midreset_out_valid", int'(out_valid), 0);
    check_output("midreset_sat", int'(sat), 0);
    @(posedge clock);
    #1 reset = 1'b1;
    send_group(4, 4, 4, 4, 4);
    wait_drain("midreset", 20);
    check_output("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the `fir` filter. It consumes the filter's signed output stream `y` and runs an integrate-and-dump decimation by `DECIM`: it sums each group of `DECIM` valid samples, then rounds, scales and saturates the sum to `OUT_W` bits. Results are buffered in a small FIFO and presented to the next consumer (display formatter or host link) over a valid/ready handshake. The input side is never back-pressured; when the FIFO is full, results are dropped and flagged.

## Interface

Parameters:
- `IN_W`, default 16: width of signed input sample (the `fir` `y` width).
- `OUT_W`, default 8: width of signed output sample.
- `DECIM`, default 4: decimation factor, ≥ 2.
- `SHIFT`, default 2: arithmetic right shift applied after integration, 0 ≤ `SHIFT` < `IN_W`+clog2(`DECIM`).
- `DEPTH`, default 4: FIFO depth in results, power of two, ≥ 2.

Ports:
- `clock`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 resets all state immediately.
- `in_valid`, input, 1: `in_data` is a valid filter sample this cycle.
- `in_data`, input, `IN_W`: signed two's-complement filter output.
- `out_valid`, output, 1: FIFO non-empty; `out_data` holds the oldest result.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `out_data`, output, `OUT_W`: signed result at the FIFO head; 0 when empty.
- `drop`, output, 1: one-cycle pulse when a finished result is discarded because the FIFO is full.
- `sat`, output, 1: sticky; set when any result saturated.

## Operation

- State: accumulator `acc` (`IN_W`+clog2(`DECIM`) bits, signed), `phase` counter (0..`DECIM`-1), dump register plus its valid bit, FIFO (storage, read/write pointers, count), `sat`, `drop`.
- Integrate:
  - On `in_valid` with `phase` < `DECIM`-1: `acc` += `in_data` (sign-extended) and `phase` increments.
  - On `in_valid` with `phase` = `DECIM`-1: the dump register loads `acc`+`in_data`, dump-valid is set, `acc` clears to 0 and `phase` wraps to 0.
  - Cycles without `in_valid` hold `acc` and `phase`. Gaps between samples have no effect on the result.
- Scale:
  - r = (dump + (`SHIFT`>0 ? 2^(`SHIFT`-1) : 0)) >>> `SHIFT`, computed at full width with no intermediate overflow. This is round-half-up toward +inf.
  - The result saturates to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1]. If clamping occurred, `sat` becomes 1 and stays 1 until reset.
- FIFO write: in the cycle after dump-valid is set, the scaled value is written if a slot is free. Otherwise it is discarded and `drop` is 1 for exactly that cycle. Dump-valid clears after one cycle.
- Full condition: count = `DEPTH` and no read that cycle. A read and a write in the same cycle while full are both performed: the write is accepted, no drop occurs, and count is unchanged.
- Read: a transfer occurs when `out_valid` and `out_ready` are both 1. The head pointer advances, with wrap-around at `DEPTH`. `out_ready` while empty has no effect.
- Ordering: results leave in production order, with no reordering and no duplication.

## Timing

- Reset (asynchronous assert, `reset`=0) drives the following values:
  - `acc`=0, `phase`=0, dump-valid=0, FIFO empty.
  - `out_valid`=0, `out_data`=0, `drop`=0, `sat`=0.
- Release of `reset` is synchronous to `clock`. Assertion in mid-group discards the partial sum and all buffered results.
- Latency: the final sample of a group is sampled at edge E. The dump register loads at E. The FIFO write is at E+1, so `out_valid`=1 with the new result after E+1 when the FIFO was empty.
- `drop` is asserted after edge E+1 for one cycle.
- `out_data` and `out_valid` are registered FIFO outputs. They are stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one result per `DECIM` input samples. Input rate is up to one sample per clock.

## Test plan

Parameters for all scenarios: `IN_W`=16, `OUT_W`=8, `DECIM`=4, `SHIFT`=2, `DEPTH`=4.

- **Basic:** reset, `out_ready`=1, inputs 1,2,3,4 on consecutive cycles → `out_data`=3 (sum 10, (10+2)>>>2), `out_valid` for exactly one cycle starting after the edge following sample 4, `sat`=0.
- **Negative rounding:** inputs -5,-5,-5,-6 → `out_data`=-5 (0xFB) from (-21+2)>>>2 = -19>>>2.
- **Saturation:** four inputs of 1000 → `out_data`=127 and `sat`=1. A following group 0,0,0,0 → `out_data`=0 with `sat` still 1. Four inputs of -1000 → -128.
- **Backpressure and drop:**
  - Stimulus: `out_ready`=0, 24 samples, with group k all equal to k (k=1..6).
  - Required while stalled: results 1..4 are stored, then `drop` pulses once for group 5 and once for group 6.
  - Required after raising `out_ready`: `out_data` sequence 1,2,3,4, then `out_valid`=0.
- **Gapped input:** `in_valid` every third cycle with values 1,2,3,4 → same result 3, with `phase` holding between samples. A simultaneous read and write at full count → no `drop`.
- **Reset mid-group:** samples 100,100, then `reset`=0 for one cycle, then 4,4,4,4 → single result 4, and no result reflects the 100s.
